// File: rtl/sum_accumulator.sv
// -----------------------------------------------------------------------------
// sum_accumulator
//   Downstream stage of the 8-bit adder. Accepts a stream of unsigned sums over
//   a valid/ready handshake and adds COUNT consecutive sums into one wide total.
//   The frame total and a sticky overflow flag are then offered over a second
//   valid/ready handshake. Once the result is taken, the stage rearms for the
//   next frame.
//
// Parameters
//   SUM_W  width of an incoming sum (adder carry-out included)
//   ACC_W  accumulator / total width, must be >= SUM_W
//   COUNT  sums per frame, 1..255
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   clear         synchronous abort: drops the partial frame or pending result
//   in_valid      in_sum is valid
//   in_ready      stage can accept a sum (IDLE/ACCUM, and not in reset)
//   in_sum        unsigned sum from the adder
//   out_valid     frame result is valid (HOLD)
//   out_ready     consumer accepts the result
//   out_total     sum of COUNT inputs, modulo 2^ACC_W
//   out_overflow  a carry out of ACC_W occurred during this frame
// -----------------------------------------------------------------------------
module sum_accumulator #(
    parameter int SUM_W = 9,
    parameter int ACC_W = 16,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic             out_overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic [7:0] COUNT_C = 8'(COUNT);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [7:0]       cnt_q,   cnt_d;
    logic             ovf_q,   ovf_d;

    logic [ACC_W:0]   in_ext;
    logic [ACC_W:0]   add_w;
    logic             in_xfer;

    // One spare bit above ACC_W captures the carry out of the accumulator.
    assign in_ext = (ACC_W + 1)'(in_sum);
    assign add_w  = {1'b0, acc_q} + in_ext;

    // Handshake flags decode the registered state only, so there is no
    // combinational path from out_ready to in_ready or from in_valid to
    // out_valid. rst_n gates in_ready so the stage refuses data while in reset.
    assign in_ready  = rst_n && (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign in_xfer   = in_valid && in_ready;

    assign out_total    = acc_q;
    assign out_overflow = ovf_q;

    // NOTE: every signal driven here gets its default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (clear) begin
            // Abort wins over any transfer in the same cycle.
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_xfer) begin
                        acc_d   = in_ext[ACC_W-1:0];
                        cnt_d   = 8'd1;
                        ovf_d   = 1'b0;
                        state_d = (COUNT_C == 8'd1) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_xfer) begin
                        acc_d = add_w[ACC_W-1:0];
                        ovf_d = ovf_q | add_w[ACC_W];
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_d == COUNT_C) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Result stays stable until taken; inputs are ignored.
                    if (out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sum_accumulator
//   Two instances share one stimulus stream: a 16-bit accumulator and a 10-bit
//   one (so wrap/overflow shows up with small sums). The reference model keeps
//   the accepted sums of the current frame in a queue; expected totals are the
//   plain arithmetic sum of that queue reduced modulo 2^ACC_W, and overflow is
//   whether the true sum reached 2^ACC_W.
// -----------------------------------------------------------------------------
module tb_sum_accumulator;

    localparam int COUNT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [8:0]  in_sum = '0;

    logic        in_ready_a, out_valid_a, ovf_a;
    logic [15:0] total_a;
    logic        in_ready_b, out_valid_b, ovf_b;
    logic [9:0]  total_b;

    sum_accumulator #(.SUM_W(9), .ACC_W(16), .COUNT(COUNT)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready_a),
        .in_sum      (in_sum),
        .out_valid   (out_valid_a),
        .out_ready   (out_ready),
        .out_total   (total_a),
        .out_overflow(ovf_a)
    );

    sum_accumulator #(.SUM_W(9), .ACC_W(10), .COUNT(COUNT)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready_b),
        .in_sum      (in_sum),
        .out_valid   (out_valid_b),
        .out_ready   (out_ready),
        .out_total   (total_b),
        .out_overflow(ovf_b)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: sums accepted in the current frame, and whether the
    // frame is complete and waiting to be taken.
    int q[$];
    bit hold_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        longint s = 0;
        foreach (q[i]) s += q[i];
        chk({tag, " in_ready_a"},  32'(in_ready_a),  32'(rst_n && !hold_m));
        chk({tag, " in_ready_b"},  32'(in_ready_b),  32'(rst_n && !hold_m));
        chk({tag, " out_valid_a"}, 32'(out_valid_a), 32'(hold_m));
        chk({tag, " out_valid_b"}, 32'(out_valid_b), 32'(hold_m));
        chk({tag, " total_a"},     32'(total_a),     32'(s % 65536));
        chk({tag, " ovf_a"},       32'(ovf_a),       32'(s >= 65536));
        chk({tag, " total_b"},     32'(total_b),     32'(s % 1024));
        chk({tag, " ovf_b"},       32'(ovf_b),       32'(s >= 1024));
    endtask

    // One clock cycle: drive inputs just after the falling edge, check the
    // outputs, then advance the model by what the rising edge should do.
    task automatic step(input bit v, input logic [8:0] s, input bit ordy, input bit clr,
                        input string tag);
        in_valid  = v;
        in_sum    = s;
        out_ready = ordy;
        clear     = clr;
        #1 check_outputs(tag);
        @(posedge clk);
        if (clr) begin
            q.delete();
            hold_m = 1'b0;
        end else if (hold_m) begin
            if (ordy) begin
                q.delete();
                hold_m = 1'b0;
            end
        end else if (v) begin
            q.push_back(int'(s));
            if (q.size() == COUNT) hold_m = 1'b1;
        end
        @(negedge clk);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse(input string tag);
        #2 rst_n = 1'b0;
        q.delete();
        hold_m = 1'b0;
        #1 check_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state, before any clock edge.
        #3 check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // T1: back-to-back frame, result the cycle after the 4th sum.
        step(1, 9'h12C, 0, 0, "t1_s0");
        step(1, 9'h088, 0, 0, "t1_s1");
        step(1, 9'h13D, 0, 0, "t1_s2");
        step(1, 9'h14A, 0, 0, "t1_s3");
        #1;
        chk("t1_total",   32'(total_a),     32'h043B);
        chk("t1_ovf",     32'(ovf_a),       32'h0);
        chk("t1_valid",   32'(out_valid_a), 32'h1);
        step(0, 9'h000, 1, 0, "t1_take");

        // T2: wrap in the 10-bit instance, then a clean frame clears overflow.
        repeat (4) step(1, 9'h1FF, 0, 0, "t2_max");
        #1;
        chk("t2_total_b", 32'(total_b), 32'h3FC);
        chk("t2_ovf_b",   32'(ovf_b),   32'h1);
        step(0, 9'h000, 1, 0, "t2_take");
        repeat (4) step(1, 9'h001, 0, 0, "t2_ones");
        #1;
        chk("t2_total_b2", 32'(total_b), 32'h004);
        chk("t2_ovf_b2",   32'(ovf_b),   32'h0);
        step(0, 9'h000, 1, 0, "t2_take2");

        // T3: backpressure in HOLD with input waiting.
        repeat (4) step(1, 9'h021, 0, 0, "t3_fill");
        repeat (5) step(1, 9'h0AA, 0, 0, "t3_stall");
        step(1, 9'h0AA, 1, 0, "t3_take");
        step(1, 9'h0AA, 0, 0, "t3_first");
        #1;
        chk("t3_first_acc", 32'(total_a), 32'h00AA);
        repeat (3) step(1, 9'h003, 0, 0, "t3_rest");
        step(0, 9'h000, 1, 0, "t3_take2");

        // T4: gaps between transfers.
        for (int i = 0; i < 8; i++) step(bit'(i % 2 == 0), 9'h010, 0, 0, "t4_gap");
        #1;
        chk("t4_total", 32'(total_a), 32'h0040);
        step(0, 9'h000, 1, 0, "t4_take");

        // T5: clear mid-frame and in HOLD.
        repeat (2) step(1, 9'h055, 0, 0, "t5_part");
        step(1, 9'h055, 0, 1, "t5_clr");
        repeat (4) step(1, 9'h077, 0, 0, "t5_fill");
        step(1, 9'h077, 1, 1, "t5_clr_hold");
        repeat (4) step(1, 9'h001, 0, 0, "t5_ones");
        #1;
        chk("t5_total", 32'(total_a), 32'h0004);
        step(0, 9'h000, 1, 0, "t5_take");

        // T6: asynchronous reset mid-ACCUM and mid-HOLD.
        repeat (2) step(1, 9'h0F0, 0, 0, "t6_part");
        reset_pulse("t6_rst_accum");
        repeat (4) step(1, 9'h100, 0, 0, "t6_fill");
        reset_pulse("t6_rst_hold");
        repeat (4) step(1, 9'h0C3, 0, 0, "t6_after");
        #1;
        chk("t6_total", 32'(total_a), 32'h030C);
        step(0, 9'h000, 1, 0, "t6_take");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 3) != 0),
                 9'($urandom_range(0, 511)),
                 bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 31) == 0),
                 "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
